cluster_sequencer: RTL

Controls a combinational `priority_n` (192-key priority encoder) in the cluster-building path so that one snapshot yields several clusters, not just the lowest-addressed one. On `start_i` the block snapshots the 192 valid-pad flags and counts. It then drives the snapshot into the encoder, takes the winning address and count, masks out that key, and re-presents the snapshot. Each cycle it emits one cluster on a valid/ready output until none remain or `MXCLUSTERS` have been sent.

---
 rtl/cluster_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cluster_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cluster_sequencer
// Purpose  : Drives a combinational 192-key priority encoder repeatedly from
//            one snapshot of valid-pad flags and counts. Each pass the winning
//            key is masked out, so one snapshot yields up to MXCLUSTERS
//            clusters, emitted one per cycle on a valid/ready output.
// Ports    : clock, reset (async, active-high)
//            start_i, vpfs_i, cnts_i          - snapshot request and data
//            enc_vpfs_o, enc_cnts_o            - drive to encoder inputs
//            enc_adr_i, enc_vpf_i, enc_cnt_i   - encoder result (same cycle)
//            cluster_valid_o, out_ready_i,
//            cluster_adr_o, cluster_cnt_o,
//            cluster_idx_o                     - cluster output handshake
//            busy_o, done_o, overflow_o        - status
// Revision : 1.0 - initial release
// ============================================================================
module cluster_sequencer #(
    parameter int MXKEYS     = 192,
    parameter int MXKEYBITS  = 8,
    parameter int MXCNTB     = 3,
    parameter int MXCLUSTERS = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start_i,
    input  logic [MXKEYS-1:0]              vpfs_i,
    input  logic [MXKEYS*MXCNTB-1:0]       cnts_i,
    output logic [MXKEYS-1:0]              enc_vpfs_o,
    output logic [MXKEYS*MXCNTB-1:0]       enc_cnts_o,
    input  logic [MXKEYBITS-1:0]           enc_adr_i,
    input  logic                           enc_vpf_i,
    input  logic [MXCNTB-1:0]              enc_cnt_i,
    output logic                           cluster_valid_o,
    input  logic                           out_ready_i,
    output logic [MXKEYBITS-1:0]           cluster_adr_o,
    output logic [MXCNTB-1:0]              cluster_cnt_o,
    output logic [$clog2(MXCLUSTERS)-1:0]  cluster_idx_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           overflow_o
);

    localparam int IDXW = $clog2(MXCLUSTERS);
    localparam logic [IDXW:0]     c_idx_limit = (IDXW+1)'(MXCLUSTERS);
    localparam logic [MXKEYS-1:0] c_one       = {{(MXKEYS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [MXKEYS-1:0]          r_mask;
    logic [MXKEYS*MXCNTB-1:0]   r_cnts;
    logic [IDXW:0]              r_idx;

    logic                       w_load_ok;
    logic                       w_load;
    logic                       w_hit_limit;
    logic [IDXW:0]              w_idx_inc;
    logic [MXKEYS-1:0]          w_onehot;
    logic [MXKEYS-1:0]          w_mask_clr;

    assign enc_vpfs_o = r_mask;
    assign enc_cnts_o = r_cnts;
    assign busy_o     = (r_state != S_IDLE);

    // An out-of-range address shifts the single bit off the top, so the
    // one-hot is zero and the mask is left untouched.
    assign w_onehot    = c_one << enc_adr_i;
    assign w_mask_clr  = r_mask & ~w_onehot;
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_hit_limit = (w_idx_inc == c_idx_limit);
    assign w_load_ok   = !cluster_valid_o || out_ready_i;
    assign w_load      = (r_state == S_SCAN) && enc_vpf_i && w_load_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        done_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!enc_vpf_i) begin
                    w_state_next = S_DONE;
                end else if (w_load_ok && w_hit_limit) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Finish only once the last cluster is leaving this cycle.
                if (w_load_ok) begin
                    done_o       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mask          <= '0;
            r_cnts          <= '0;
            r_idx           <= '0;
            overflow_o      <= 1'b0;
            cluster_valid_o <= 1'b0;
            cluster_adr_o   <= '0;
            cluster_cnt_o   <= '0;
            cluster_idx_o   <= '0;
        end else begin
            if ((r_state == S_IDLE) && start_i) begin
                r_mask     <= vpfs_i;
                r_cnts     <= cnts_i;
                r_idx      <= '0;
                overflow_o <= 1'b0;
            end
            if (w_load) begin
                cluster_valid_o <= 1'b1;
                cluster_adr_o   <= enc_adr_i;
                cluster_cnt_o   <= enc_cnt_i;
                cluster_idx_o   <= r_idx[IDXW-1:0];
                r_mask          <= w_mask_clr;
                r_idx           <= w_idx_inc;
                if (w_hit_limit) begin
                    overflow_o <= |w_mask_clr;
                end
            end else if (cluster_valid_o && out_ready_i) begin
                cluster_valid_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
